// File: rtl/ddr4_burst_traffic_checker.sv
// Avalon-MM burst write / pipelined read-back pattern checker for the DDR4 EMIF user port.
// Define DDR_CHECKER_TIMEOUT_EN to enable the read-phase watchdog (TIMEOUT cycles without progress).
module ddr4_burst_traffic_checker #(
  parameter int ADDR_W     = 26,
  parameter int DATA_W     = 512,
  parameter int BE_W       = 64,
  parameter int BURST_LEN  = 8,
  parameter int NUM_BURSTS = 16,
  parameter int TIMEOUT    = 4095
) (
  input  logic              sync_clk,
  input  logic              reset,
  input  logic              cal_success,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              avl_ready,
  input  logic              avl_rdata_valid,
  input  logic [DATA_W-1:0] avl_rdata,
  output logic [ADDR_W-1:0] avl_addr,
  output logic [DATA_W-1:0] avl_wdata,
  output logic [BE_W-1:0]   avl_be,
  output logic              avl_read_req,
  output logic              avl_write_req,
  output logic [6:0]        avl_size,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_cnt,
  output logic [15:0]       first_err_beat,
  output logic              timeout
);

  localparam int CNT_W = 20;
  localparam logic [CNT_W-1:0] TOTAL = CNT_W'(NUM_BURSTS * BURST_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD_REQ,
    S_RD_WAIT,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [6:0]        beat_q, beat_d;
  logic [12:0]       burst_q, burst_d;
  logic [15:0]       w_q, w_d;
  logic [CNT_W-1:0]  r_q, r_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [15:0]       err_cnt_q, err_cnt_d;
  logic [15:0]       first_err_q, first_err_d;
  logic              timeout_flag;

  logic wr_fire, rd_fire, rd_active, rx_beat, last_beat, last_burst, mismatch;

`ifdef DDR_CHECKER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            timeout_q, timeout_d;
  assign timeout_flag = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT != 0);
  assign timeout_flag = 1'b0;
`endif

  function automatic logic [DATA_W-1:0] pattern(input logic [15:0] w);
    logic [DATA_W-1:0] p;
    p = '0;
    for (int unsigned k = 0; k < DATA_W / 32; k++)
      p[32*k +: 32] = {w, 8'(k), 8'hA5};
    return p;
  endfunction

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    addr_d      = addr_q;
    beat_d      = beat_q;
    burst_d     = burst_q;
    w_d         = w_q;
    r_d         = r_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;
`ifdef DDR_CHECKER_TIMEOUT_EN
    wd_d        = wd_q;
    timeout_d   = timeout_q;
`endif

    wr_fire    = (state_q == S_WR) && avl_ready;
    rd_fire    = (state_q == S_RD_REQ) && avl_ready;
    rd_active  = (state_q == S_RD_REQ) || (state_q == S_RD_WAIT);
    rx_beat    = rd_active && avl_rdata_valid && (r_q != TOTAL);
    last_beat  = (beat_q == 7'(BURST_LEN - 1));
    last_burst = (burst_q == 13'(NUM_BURSTS - 1));
    mismatch   = (avl_rdata != pattern(r_q[15:0]));

    case (state_q)
      S_IDLE: begin
        if (start && cal_success) begin
          base_d      = start_addr;
          addr_d      = start_addr;
          beat_d      = '0;
          burst_d     = '0;
          w_d         = '0;
          r_d         = '0;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          err_cnt_d   = '0;
          first_err_d = '1;
`ifdef DDR_CHECKER_TIMEOUT_EN
          wd_d        = '0;
          timeout_d   = 1'b0;
`endif
          state_d     = S_WR;
        end
      end
      S_WR: begin
        if (wr_fire) begin
          w_d = w_q + 16'd1;
          if (last_beat) begin
            beat_d = '0;
            if (last_burst) begin
              // Read-back walks the same burst addresses from the latched base.
              burst_d = '0;
              addr_d  = base_q;
              state_d = S_RD_REQ;
            end else begin
              burst_d = burst_q + 13'd1;
              addr_d  = addr_q + ADDR_W'(BURST_LEN);
            end
          end else begin
            beat_d = beat_q + 7'd1;
          end
        end
      end
      S_RD_REQ: begin
        if (rd_fire) begin
          if (last_burst) begin
            state_d = S_RD_WAIT;
          end else begin
            burst_d = burst_q + 13'd1;
            addr_d  = addr_q + ADDR_W'(BURST_LEN);
          end
        end
      end
      S_RD_WAIT: ;
      S_DONE: begin
        done_d  = 1'b1;
        pass_d  = (err_cnt_q == '0) && !timeout_flag;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Compare folds into err_cnt at the valid's edge, so DONE always sees the final beat.
    if (rx_beat) begin
      r_d = r_q + CNT_W'(1);
      if (mismatch) begin
        if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
        if (first_err_q == 16'hFFFF) first_err_d = r_q[15:0];
      end
    end

    if (rd_active && (r_q == TOTAL)) state_d = S_DONE;

`ifdef DDR_CHECKER_TIMEOUT_EN
    if (rd_active) begin
      if (avl_rdata_valid || rd_fire) wd_d = '0;
      else if (wd_q != WD_MAX)        wd_d = wd_q + WD_W'(1);
      if ((wd_q == WD_MAX) && (r_q != TOTAL)) begin
        timeout_d = 1'b1;
        state_d   = S_DONE;
      end
    end
`endif
  end

  always_ff @(posedge sync_clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      addr_q      <= '0;
      beat_q      <= '0;
      burst_q     <= '0;
      w_q         <= '0;
      r_q         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_cnt_q   <= '0;
      first_err_q <= '1;
`ifdef DDR_CHECKER_TIMEOUT_EN
      wd_q        <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      addr_q      <= addr_d;
      beat_q      <= beat_d;
      burst_q     <= burst_d;
      w_q         <= w_d;
      r_q         <= r_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
`ifdef DDR_CHECKER_TIMEOUT_EN
      wd_q        <= wd_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  assign avl_write_req  = (state_q == S_WR);
  assign avl_read_req   = (state_q == S_RD_REQ);
  assign avl_addr       = (avl_write_req || avl_read_req) ? addr_q : '0;
  assign avl_wdata      = avl_write_req ? pattern(w_q) : '0;
  assign avl_be         = '1;
  assign avl_size       = 7'(BURST_LEN);
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_cnt        = err_cnt_q;
  assign first_err_beat = first_err_q;
  assign timeout        = timeout_flag;

endmodule

// File: tb/tb_ddr4_burst_traffic_checker.sv
// Randomized bench for ddr4_burst_traffic_checker against a queue-based Avalon memory model.
module tb_ddr4_burst_traffic_checker;

  localparam int AW    = 12;
  localparam int DW    = 128;
  localparam int BW    = 16;
  localparam int BL    = 4;
  localparam int NB    = 2;
  localparam int TO    = 100;
  localparam int TOTAL = NB * BL;

  logic          clk;
  logic          reset;
  logic          cal_success;
  logic          start;
  logic [AW-1:0] start_addr;
  logic          avl_ready;
  logic          avl_rdata_valid;
  logic [DW-1:0] avl_rdata;
  logic [AW-1:0] avl_addr;
  logic [DW-1:0] avl_wdata;
  logic [BW-1:0] avl_be;
  logic          avl_read_req;
  logic          avl_write_req;
  logic [6:0]    avl_size;
  logic          busy;
  logic          done;
  logic          pass;
  logic [15:0]   err_cnt;
  logic [15:0]   first_err_beat;
  logic          timeout;

  ddr4_burst_traffic_checker #(
    .ADDR_W(AW), .DATA_W(DW), .BE_W(BW),
    .BURST_LEN(BL), .NUM_BURSTS(NB), .TIMEOUT(TO)
  ) dut (
    .sync_clk(clk), .reset(reset), .cal_success(cal_success), .start(start),
    .start_addr(start_addr), .avl_ready(avl_ready), .avl_rdata_valid(avl_rdata_valid),
    .avl_rdata(avl_rdata), .avl_addr(avl_addr), .avl_wdata(avl_wdata), .avl_be(avl_be),
    .avl_read_req(avl_read_req), .avl_write_req(avl_write_req), .avl_size(avl_size),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .first_err_beat(first_err_beat), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int w);
    logic [DW-1:0] p;
    for (int k = 0; k < DW / 32; k++) p[32*k +: 32] = {w[15:0], k[7:0], 8'hA5};
    return p;
  endfunction

  // Environment state shared between the memory model and the sequence
  int            cyc = 0;
  int            ready_mode = 0;
  int            flip_idx = -1;
  int            drop_idx = -1;
  int            wr_k = 0;
  int            rd_k = 0;
  int            rsp_idx = 0;
  int            last_valid_cyc = 0;
  logic [AW-1:0] run_addr = '0;
  logic [AW-1:0] rsp_q[$];
  logic [DW-1:0] mem[int];

  initial begin
    logic [AW-1:0] a, e;
    logic [DW-1:0] d;
    logic [DW-1:0] st_wdata;
    logic [AW-1:0] st_addr;
    bit            stall;
    stall = 0;
    avl_ready = 1'b0;
    avl_rdata_valid = 1'b0;
    avl_rdata = '0;
    forever begin
      @(negedge clk);
      cyc++;
      case (ready_mode)
        0:       avl_ready = 1'b1;
        1:       avl_ready = ~avl_ready;
        default: avl_ready = 1'($urandom_range(0, 1));
      endcase
      // Read responses leave the memory in request order, at most one per cycle.
      avl_rdata_valid = 1'b0;
      avl_rdata = '0;
      if (rsp_q.size() > 0 && (ready_mode == 0 || $urandom_range(0, 3) != 0)) begin
        a = rsp_q.pop_front();
        d = mem.exists(int'(a)) ? mem[int'(a)] : '0;
        if (rsp_idx == flip_idx) d[0] = ~d[0];
        if (rsp_idx != drop_idx) begin
          avl_rdata_valid = 1'b1;
          avl_rdata = d;
          last_valid_cyc = cyc;
        end
        rsp_idx++;
      end
      if (avl_write_req) begin
        if (stall) begin
          check_eq("hold_addr", DW'(avl_addr), DW'(st_addr));
          check_eq("hold_wdata", avl_wdata, st_wdata);
        end
        if (avl_ready) begin
          e = AW'(run_addr + AW'((wr_k / BL) * BL));
          check_eq("wr_addr", DW'(avl_addr), DW'(e));
          check_eq("wr_size", DW'(avl_size), DW'(BL));
          check_eq("wr_data", avl_wdata, pat(wr_k));
          mem[int'(AW'(avl_addr + AW'(wr_k % BL)))] = avl_wdata;
          wr_k++;
          stall = 0;
        end else begin
          stall = 1;
          st_addr = avl_addr;
          st_wdata = avl_wdata;
        end
      end else begin
        stall = 0;
      end
      if (avl_read_req && avl_ready) begin
        e = AW'(run_addr + AW'(rd_k * BL));
        check_eq("rd_addr", DW'(avl_addr), DW'(e));
        for (int i = 0; i < BL; i++) rsp_q.push_back(AW'(avl_addr + AW'(i)));
        rd_k++;
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    logic [BW-1:0] ones;
    ones = '1;
    check_eq({tag, "_busy"}, DW'(busy), '0);
    check_eq({tag, "_done"}, DW'(done), '0);
    check_eq({tag, "_pass"}, DW'(pass), '0);
    check_eq({tag, "_tout"}, DW'(timeout), '0);
    check_eq({tag, "_errcnt"}, DW'(err_cnt), '0);
    check_eq({tag, "_ferr"}, DW'(first_err_beat), DW'(16'hFFFF));
    check_eq({tag, "_wreq"}, DW'(avl_write_req), '0);
    check_eq({tag, "_rreq"}, DW'(avl_read_req), '0);
    check_eq({tag, "_addr"}, DW'(avl_addr), '0);
    check_eq({tag, "_wdata"}, avl_wdata, '0);
    check_eq({tag, "_be"}, DW'(avl_be), DW'(ones));
    check_eq({tag, "_size"}, DW'(avl_size), DW'(BL));
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && rsp_q.size() > 0; n++) @(negedge clk);
    check_eq("drain", DW'(rsp_q.size()), '0);
  endtask

  task automatic kick(input logic [AW-1:0] sa, input int mode, input int flip, input int drop);
    ready_mode = mode;
    flip_idx = flip;
    drop_idx = drop;
    wr_k = 0;
    rd_k = 0;
    rsp_idx = 0;
    run_addr = sa;
    start_addr = sa;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_test(input logic [AW-1:0] sa, input int mode, input int flip,
                          input int drop, input bit cal_glitch);
    int          exp_err;
    logic [15:0] exp_first;
    bit          exp_to, got_done;
    int          done_cyc;
    drain();
    exp_err   = (flip >= 0 && flip < TOTAL) ? 1 : 0;
    exp_first = (exp_err != 0) ? 16'(flip) : 16'hFFFF;
    exp_to    = (drop >= 0);
    kick(sa, mode, flip, drop);
    check_eq("start_busy", DW'(busy), DW'(1));
    check_eq("start_done_clr", DW'(done), '0);
    check_eq("start_err_clr", DW'(err_cnt), '0);
    check_eq("start_ferr_clr", DW'(first_err_beat), DW'(16'hFFFF));
    if (cal_glitch) cal_success = 1'b0;
    got_done = 0;
    done_cyc = 0;
    for (int n = 0; n < 3000 && !got_done; n++) begin
      @(negedge clk);
      if (done) begin
        got_done = 1;
        done_cyc = cyc;
      end
    end
    cal_success = 1'b1;
    check_eq("done_wait", DW'(got_done), DW'(1));
    check_eq("end_busy", DW'(busy), '0);
    check_eq("end_pass", DW'(pass), DW'(exp_err == 0 && !exp_to));
    check_eq("end_errcnt", DW'(err_cnt), DW'(exp_err));
    check_eq("end_ferr", DW'(first_err_beat), DW'(exp_first));
    check_eq("end_tout", DW'(timeout), DW'(exp_to));
    check_eq("wr_beats", DW'(wr_k), DW'(TOTAL));
    check_eq("rd_reqs", DW'(rd_k), DW'(NB));
    if (exp_to)
      check_eq("tout_latency", DW'(done_cyc - last_valid_cyc >= TO &&
                                  done_cyc - last_valid_cyc <= TO + 6), DW'(1));
  endtask

  initial begin
    bit got;
    int f;
    reset = 1'b1;
    cal_success = 1'b1;
    start = 1'b0;
    start_addr = '0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    reset = 1'b0;

    run_test(12'h100, 0, -1, -1, 0);

    // Start without calibration is ignored; sticky done from the previous run stays.
    cal_success = 1'b0;
    kick(12'h100, 0, -1, -1);
    repeat (5) @(negedge clk);
    check_eq("nocal_busy", DW'(busy), '0);
    check_eq("nocal_wreq", DW'(avl_write_req), '0);
    check_eq("nocal_wbeats", DW'(wr_k), '0);
    check_eq("nocal_done", DW'(done), DW'(1));
    cal_success = 1'b1;

    run_test(12'h100, 1, -1, -1, 1);
    run_test(12'h100, 0, 5, -1, 0);
    run_test(12'hFFC, 2, -1, -1, 0);
    for (int i = 0; i < 4; i++) begin
      f = $urandom_range(0, TOTAL + 3);
      if (f >= TOTAL) f = -1;
      run_test(AW'($urandom), 2, f, -1, 0);
    end

    // Reset during read-back while the memory keeps returning (corrupted) beats.
    drain();
    kick(12'h200, 0, 6, -1);
    got = 0;
    for (int n = 0; n < 500 && !got; n++) begin
      @(negedge clk);
      if (rsp_idx >= 3) got = 1;
    end
    check_eq("midrd_reach", DW'(got), DW'(1));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_vals("midrst");
    repeat (8) @(negedge clk);
    check_eq("stray_errcnt", DW'(err_cnt), '0);
    check_eq("stray_busy", DW'(busy), '0);
    check_eq("stray_ferr", DW'(first_err_beat), DW'(16'hFFFF));
    run_test(12'h040, 0, -1, -1, 0);

`ifdef DDR_CHECKER_TIMEOUT_EN
    run_test(12'h300, 0, -1, TOTAL - 1, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
